// File: rtl/acc_i8v4_i16v4.sv
// rtl/acc_i8v4_i16v4.sv - 4-lane signed accumulator over COUNT beats with valid/ready output
module acc_i8v4_i16v4 #(
    parameter int LANE_W = 8,
    parameter int ACC_W  = 16,
    parameter int COUNT  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [LANE_W-1:0] a_0,
    input  logic signed [LANE_W-1:0] a_1,
    input  logic signed [LANE_W-1:0] a_2,
    input  logic signed [LANE_W-1:0] a_3,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  y_0,
    output logic signed [ACC_W-1:0]  y_1,
    output logic signed [ACC_W-1:0]  y_2,
    output logic signed [ACC_W-1:0]  y_3
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc [4];
    logic signed [ACC_W-1:0] sum [4];
    logic signed [LANE_W-1:0] lane [4];
    logic                    accept;
    logic                    last_beat;

    assign lane[0] = a_0;
    assign lane[1] = a_1;
    assign lane[2] = a_2;
    assign lane[3] = a_3;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign last_beat = (cnt == CNT_W'(COUNT - 1));

    // Size cast of a signed lane sign-extends; addition wraps modulo 2^ACC_W.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sum[i] = acc[i] + ACC_W'(lane[i]);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (accept && last_beat) state_next = HOLD;
            HOLD:  if (out_ready)           state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
            y_0 <= '0;
            y_1 <= '0;
            y_2 <= '0;
            y_3 <= '0;
        end else if (accept) begin
            if (last_beat) begin
                cnt <= '0;
                for (int i = 0; i < 4; i++) acc[i] <= '0;
                y_0 <= sum[0];
                y_1 <= sum[1];
                y_2 <= sum[2];
                y_3 <= sum[3];
            end else begin
                cnt <= cnt + 1'b1;
                for (int i = 0; i < 4; i++) acc[i] <= sum[i];
            end
        end
    end

endmodule
